// File: rtl/seg7_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg7_pkg : shared types and constants for the display scheduler |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package seg7_pkg;
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   localparam int   FRAME_W  = 64;
   localparam logic MODE_HEX = 1'b0;
   localparam logic MODE_RAW = 1'b1;
endpackage
`default_nettype wire

// File: rtl/seg7_disp_sched_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg7_disp_sched_if : requester handshake and display frame bus  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface seg7_disp_sched_if #(
   parameter int NREQ = 4
);
   import seg7_pkg::*;
   localparam int OW = $clog2(NREQ);

   logic [NREQ-1:0]         req_valid;
   logic [FRAME_W*NREQ-1:0] req_data;
   logic [NREQ-1:0]         req_mode;
   logic [NREQ-1:0]         req_ready;
   logic                    freeze;
   logic [FRAME_W-1:0]      disp_data;
   logic                    disp_mode;
   logic [OW-1:0]           disp_owner;
   logic                    disp_busy;

   modport master (
      output req_valid, req_data, req_mode, freeze,
      input  req_ready, disp_data, disp_mode, disp_owner, disp_busy
   );

   modport slave (
      input  req_valid, req_data, req_mode, freeze,
      output req_ready, disp_data, disp_mode, disp_owner, disp_busy
   );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant, search from last+1|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int LW   = $clog2(NREQ)
) (
   input  wire logic [NREQ-1:0] req,
   input  wire logic [LW-1:0]   last,
   input  wire logic            en,
   output logic [NREQ-1:0]      gnt
);
   logic [LW-1:0] idx;
   logic          found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = LW'((int'(last) + k) % NREQ);
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/seg7_disp_sched.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seg7_disp_sched : round-robin display sharing with min dwell    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module seg7_disp_sched #(
   parameter int NREQ  = 4,
   parameter int DWELL = 50_000_000,
   parameter int CW    = 26
) (
   input wire logic         clk,
   input wire logic         rst,
   seg7_disp_sched_if.slave bus
);
   import seg7_pkg::*;

   localparam int            OW       = $clog2(NREQ);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [FRAME_W-1:0] data_q, data_d;
   logic               mode_q, mode_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [OW-1:0]      last_q, last_d;

   logic               win_open;
   logic               accept;
   logic [NREQ-1:0]    gnt;
   logic [OW-1:0]      gnt_idx;
   logic [FRAME_W-1:0] gnt_frame;
   logic               gnt_mode;

   // freeze overrides an otherwise open window
   assign win_open = !bus.freeze && ((state_q == IDLE) || (cnt_q == '0));
   assign accept   = |gnt;

   rr_arbiter #(.NREQ(NREQ), .LW(OW)) u_arb (
      .req  (bus.req_valid),
      .last (last_q),
      .en   (win_open),
      .gnt  (gnt)
   );

   always_comb begin
      gnt_idx   = '0;
      gnt_frame = '0;
      gnt_mode  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_idx   = OW'(i);
            gnt_frame = bus.req_data[i*FRAME_W +: FRAME_W];
            gnt_mode  = bus.req_mode[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         mode_q  <= MODE_HEX;
         owner_q <= '0;
         last_q  <= OW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      mode_d  = mode_q;
      owner_d = owner_q;
      last_d  = last_q;
      if (accept) begin
         state_d = SHOW;
         cnt_d   = CNT_LOAD;
         data_d  = gnt_frame;
         mode_d  = gnt_mode;
         owner_d = gnt_idx;
         last_d  = gnt_idx;
      end else if (!bus.freeze && (state_q == SHOW)) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      bus.req_ready  = gnt;
      bus.disp_busy  = (state_q == SHOW);
      bus.disp_data  = data_q;
      bus.disp_mode  = mode_q;
      bus.disp_owner = owner_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_seg7_disp_sched.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_seg7_disp_sched : random requesters vs dwell/round-robin model|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_seg7_disp_sched;
   import seg7_pkg::*;

   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   seg7_disp_sched_if #(.NREQ(NR)) bus0 ();
   seg7_disp_sched_if #(.NREQ(NR)) bus1 ();

   seg7_disp_sched #(.NREQ(NR), .DWELL(4), .CW(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   seg7_disp_sched #(.NREQ(NR), .DWELL(1), .CW(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int total = 0;
   int bad   = 0;

   // requester stimulus per DUT
   logic [NR-1:0] v   [2];
   logic [63:0]   d   [2][NR];
   logic [NR-1:0] md  [2];
   logic          frz [2];
   int            stim_mode;   // 0: drop on accept, 1: random, 2: hold

   // reference model: age = unfrozen cycles since the grant, window opens at age >= dwell
   bit          m_show [2];
   int          m_age  [2];
   int          m_last [2];
   logic [63:0] m_data [2];
   logic        m_mode [2];
   int          m_owner[2];

   function automatic int dwell(int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_show[k] = 0; m_age[k] = 0; m_last[k] = NR - 1;
         m_data[k] = '0; m_mode[k] = 1'b0; m_owner[k] = 0;
         v[k] = '0; md[k] = '0; frz[k] = 1'b0;
         for (int i = 0; i < NR; i++) d[k][i] = '0;
      end
   endtask

   function automatic int exp_grant(int k);
      int idx;
      if (frz[k] || (m_show[k] && m_age[k] < dwell(k))) return -1;
      for (int j = 1; j <= NR; j++) begin
         idx = (m_last[k] + j) % NR;
         if (v[k][idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_update(int k, int g);
      if (g >= 0) begin
         m_data[k] = d[k][g]; m_mode[k] = md[k][g];
         m_owner[k] = g; m_last[k] = g;
         m_show[k] = 1; m_age[k] = 1;
      end else if (!frz[k] && m_show[k]) begin
         if (m_age[k] < dwell(k)) m_age[k]++;
         else m_show[k] = 0;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bus0.req_data[64*i +: 64] = d[0][i];
         bus1.req_data[64*i +: 64] = d[1][i];
      end
      bus0.req_valid = v[0]; bus0.req_mode = md[0]; bus0.freeze = frz[0];
      bus1.req_valid = v[1]; bus1.req_mode = md[1]; bus1.freeze = frz[1];
   endtask

   task automatic stim_next(int k, int g);
      if (stim_mode == 0 && g >= 0) v[k][g] = 1'b0;
      if (stim_mode == 1) begin
         if (g >= 0 && ($urandom % 2 == 0)) v[k][g] = 1'b0;
         for (int i = 0; i < NR; i++) begin
            if (!v[k][i] && ($urandom % 3 == 0)) begin
               v[k][i]  = 1'b1;
               d[k][i]  = {$urandom, $urandom};
               md[k][i] = 1'($urandom);
            end
         end
         frz[k] = ($urandom % 8 == 0);
      end
   endtask

   task automatic step();
      int g[2];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         g[k] = exp_grant(k);
         check_eq($sformatf("ready%0d", k),
                  64'((k == 0) ? bus0.req_ready : bus1.req_ready),
                  (g[k] < 0) ? 64'd0 : (64'd1 << g[k]));
         check_eq($sformatf("data%0d", k), (k == 0) ? bus0.disp_data : bus1.disp_data, m_data[k]);
         check_eq($sformatf("mode%0d", k), 64'((k == 0) ? bus0.disp_mode : bus1.disp_mode), 64'(m_mode[k]));
         check_eq($sformatf("owner%0d", k), 64'((k == 0) ? bus0.disp_owner : bus1.disp_owner), 64'(m_owner[k]));
         check_eq($sformatf("busy%0d", k), 64'((k == 0) ? bus0.disp_busy : bus1.disp_busy), 64'(m_show[k]));
      end
      for (int k = 0; k < 2; k++) model_update(k, g[k]);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) stim_next(k, g[k]);
      drive();
   endtask

   task automatic check_reset_outputs(string tag);
      check_eq({tag, "_rdy0"},  64'(bus0.req_ready), 64'd0);
      check_eq({tag, "_data0"}, bus0.disp_data, 64'd0);
      check_eq({tag, "_mode0"}, 64'(bus0.disp_mode), 64'd0);
      check_eq({tag, "_own0"},  64'(bus0.disp_owner), 64'd0);
      check_eq({tag, "_busy0"}, 64'(bus0.disp_busy), 64'd0);
      check_eq({tag, "_data1"}, bus1.disp_data, 64'd0);
      check_eq({tag, "_busy1"}, 64'(bus1.disp_busy), 64'd0);
   endtask

   initial begin
      stim_mode = 0;
      model_reset();
      drive();
      #1 rst = 1'b1;
      #2 check_reset_outputs("rst");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // single request, then dwell expires with no request
      v[0][0] = 1'b1; d[0][0] = 64'h1234_5678; md[0][0] = MODE_HEX;
      drive();
      step();
      check_eq("single_data", bus0.disp_data, 64'h1234_5678);
      check_eq("single_busy", 64'(bus0.disp_busy), 64'd1);
      repeat (4) step();
      check_eq("single_idle", 64'(bus0.disp_busy), 64'd0);
      check_eq("single_keep", bus0.disp_data, 64'h1234_5678);

      // raw mode pass-through on requester 2
      v[0][2] = 1'b1; d[0][2] = 64'hC0F9_A4B0_9992_82F8; md[0][2] = MODE_RAW;
      drive();
      step();
      check_eq("raw_mode", 64'(bus0.disp_mode), 64'd1);
      check_eq("raw_data", bus0.disp_data, 64'hC0F9_A4B0_9992_82F8);
      repeat (4) step();

      // continuous all-request round robin, and DWELL=1 alternation
      stim_mode = 2;
      v[0] = 4'b1111; v[1] = 4'b0011;
      for (int i = 0; i < NR; i++) begin
         d[0][i] = {32'hA0A0_0000, 32'(i)}; d[1][i] = {32'h0B0B_0000, 32'(i)};
      end
      drive();
      repeat (17) step();
      stim_mode = 0;
      v[0] = '0; v[1] = '0;
      drive();
      repeat (5) step();

      stim_mode = 1;
      repeat (2000) step();

      // async reset at cnt=1 (two edges after the grant edge)
      stim_mode = 0;
      v[0] = '0; v[1] = '0; frz[0] = 1'b0; frz[1] = 1'b0;
      drive();
      repeat (6) step();
      v[0][1] = 1'b1; d[0][1] = 64'hDEAD_BEEF_0000_0001; md[0][1] = 1'b1;
      drive();
      repeat (3) step();
      check_eq("pre_rst_busy", 64'(bus0.disp_busy), 64'd1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      @(negedge clk) rst = 1'b0;
      model_reset();
      drive();
      @(posedge clk); #1;

      stim_mode = 1;
      repeat (500) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
